datapath_unit: RTL and testbench

DATAPATH_UNIT -- requirements
Module: datapath_unit

---
 rtl/datapath_unit.sv | 127 ++++++++++++
 tb/tb_datapath_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - micro-order driven datapath (PC/MAR/IR/MBR/BR/ACC/MR + ALU)
// Optional signed multiplier enabled by defining DATAPATH_MPY_EN.
module datapath_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] control_signal,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  data_from_ir,
  output logic [7:0]  flags,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we
);

  logic [7:0]  pc, mar, ir;
  logic [15:0] mbr, br, acc, mr;
  logic [3:0]  flag_q;

  logic [10:0] acc_ops;
  logic [16:0] sum, diff;
  logic [15:0] alu_result;
  logic        op_hit, acc_we, c_flag, v_flag;
  logic [15:0] acc_next;
  logic        unused_bits;

  assign unused_bits = ^{control_signal[19:17], control_signal[14], control_signal[9], control_signal[7]};

`ifdef DATAPATH_MPY_EN
  logic signed [31:0] product;
  assign product = $signed(acc) * $signed(br);
  assign acc_ops = control_signal[31:21];
`else
  // Without the multiplier the mpy bit is simply not an ACC op.
  assign acc_ops = control_signal[31:21] & ~11'b001_0000_0000;
  assign mr      = 16'h0000;
`endif

  assign sum  = {1'b0, acc} + {1'b0, br};
  assign diff = {1'b0, acc} + {1'b0, ~br} + 17'd1;

  // Lowest asserted ACC-op bit wins; no op lets mbr2acc load ACC.
  always_comb begin
    alu_result = acc;
    op_hit     = 1'b1;
    c_flag     = 1'b0;
    v_flag     = 1'b0;
    if (acc_ops[0]) alu_result = 16'h0000;
    else if (acc_ops[1]) begin
      alu_result = sum[15:0];
      c_flag     = sum[16];
      v_flag     = (acc[15] == br[15]) && (sum[15] != acc[15]);
    end else if (acc_ops[2]) begin
      alu_result = diff[15:0];
      c_flag     = diff[16];
      v_flag     = (acc[15] != br[15]) && (diff[15] != acc[15]);
    end else if (acc_ops[3]) alu_result = acc & br;
    else if (acc_ops[4]) alu_result = acc | br;
    else if (acc_ops[5]) alu_result = ~br;
    else if (acc_ops[6]) begin
      alu_result = {acc[14:0], 1'b0};
      c_flag     = acc[15];
    end else if (acc_ops[7]) begin
      alu_result = {1'b0, acc[15:1]};
      c_flag     = acc[0];
    end
`ifdef DATAPATH_MPY_EN
    else if (acc_ops[8]) alu_result = product[15:0];
`endif
    else if (acc_ops[9]) begin
      alu_result = {acc[14:0], 1'b0};
      c_flag     = acc[15];
    end else if (acc_ops[10]) begin
      alu_result = {acc[15], acc[15:1]};
      c_flag     = acc[0];
    end else op_hit = 1'b0;
  end

  assign acc_we   = op_hit | control_signal[10];
  assign acc_next = op_hit ? alu_result : mbr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= 8'h00;
      mar          <= 8'h00;
      ir           <= 8'h00;
      mbr          <= 16'h0000;
      br           <= 16'h0000;
      acc          <= 16'h0000;
      data_from_ir <= 8'h00;
      flag_q       <= 4'h0;
    end else begin
      if (control_signal[8])      mar <= mbr[7:0];
      else if (control_signal[2]) mar <= pc;

      if (control_signal[3])       pc <= mbr[7:0];
      else if (control_signal[20]) pc <= pc + 8'd1;

      if (control_signal[5])       mbr <= mem_rdata;
      else if (control_signal[16]) mbr <= alu_result;
      else if (control_signal[15]) mbr <= mr;
      else if (control_signal[11]) mbr <= acc;
      else if (control_signal[1])  mbr <= {8'h00, pc};

      if (control_signal[4])  ir           <= mbr[15:8];
      if (control_signal[13]) data_from_ir <= ir;
      if (control_signal[6])  br           <= mbr;

      if (acc_we) begin
        acc    <= acc_next;
        flag_q <= {v_flag, c_flag, (acc_next == 16'h0000), acc_next[15]};
      end
    end
  end

`ifdef DATAPATH_MPY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mr <= 16'h0000;
    else if (acc_ops[8] && acc_ops[7:0] == 8'h00) mr <= product[31:16];
  end
`endif

  assign flags     = {4'h0, flag_q};
  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign mem_we    = control_signal[12] & control_signal[0] & ~rst;

endmodule

// File: tb/tb_datapath_unit.sv
// tb/tb_datapath_unit.sv - directed self-checking bench for datapath_unit
module tb_datapath_unit;

  logic        clk;
  logic        rst;
  logic [31:0] control_signal;
  logic [15:0] mem_rdata;
  logic [7:0]  data_from_ir;
  logic [7:0]  flags;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] MAR2MEM  = 32'h0000_0001;
  localparam logic [31:0] PC2MBR   = 32'h0000_0002;
  localparam logic [31:0] PC2MAR   = 32'h0000_0004;
  localparam logic [31:0] MBR2PC   = 32'h0000_0008;
  localparam logic [31:0] MBR2IR   = 32'h0000_0010;
  localparam logic [31:0] MEM2MBR  = 32'h0000_0020;
  localparam logic [31:0] MBR2BR   = 32'h0000_0040;
  localparam logic [31:0] ACC2ALU  = 32'h0000_0080;
  localparam logic [31:0] MBR2MAR  = 32'h0000_0100;
  localparam logic [31:0] MBR2ACC  = 32'h0000_0400;
  localparam logic [31:0] ACC2MBR  = 32'h0000_0800;
  localparam logic [31:0] MBR2MEM  = 32'h0000_1000;
  localparam logic [31:0] IR2CU    = 32'h0000_2000;
  localparam logic [31:0] BR2ALU   = 32'h0000_4000;
  localparam logic [31:0] MR2MBR   = 32'h0000_8000;
  localparam logic [31:0] CAR_BITS = 32'h000E_0000;
  localparam logic [31:0] PC_PLUS1 = 32'h0010_0000;
  localparam logic [31:0] ACC_CLR  = 32'h0020_0000;
  localparam logic [31:0] OP_ADD   = 32'h0040_0000;
  localparam logic [31:0] OP_SUB   = 32'h0080_0000;
  localparam logic [31:0] OP_MPY   = 32'h2000_0000;
  localparam logic [31:0] OP_ASR   = 32'h8000_0000;

  datapath_unit dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .mem_rdata      (mem_rdata),
    .data_from_ir   (data_from_ir),
    .flags          (flags),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One micro-order cycle: drive, take the edge, sample 1 time unit later.
  task automatic cyc(input logic [31:0] cs, input logic [15:0] rd);
    control_signal = cs;
    mem_rdata      = rd;
    @(posedge clk);
    #1;
    control_signal = 32'h0;
  endtask

  initial begin
    rst            = 1'b1;
    control_signal = 32'hFFFF_FFFF;
    mem_rdata      = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ir",    {24'h0, data_from_ir}, 32'h0);
    check("rst_flags", {24'h0, flags},        32'h0);
    check("rst_addr",  {24'h0, mem_addr},     32'h0);
    check("rst_wdata", {16'h0, mem_wdata},    32'h0);
    check("rst_we",    {31'h0, mem_we},       32'h0);
    control_signal = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_addr",  {24'h0, mem_addr},  32'h0);
    check("hold_wdata", {16'h0, mem_wdata}, 32'h0);
    check("hold_flags", {24'h0, flags},     32'h0);

    // Fetch from PC=0x05
    repeat (5) cyc(PC_PLUS1, 16'h0);
    cyc(PC2MAR, 16'h0);
    check("fetch_addr", {24'h0, mem_addr}, 32'h05);
    cyc(MAR2MEM | MEM2MBR, 16'h0312);
    check("fetch_mbr", {16'h0, mem_wdata}, 32'h0312);
    cyc(MBR2IR, 16'h0);
    cyc(IR2CU, 16'h0);
    check("fetch_ir", {24'h0, data_from_ir}, 32'h03);

    // Arithmetic: 0x7FFF + 1, then 0x8000 - 0x8000
    cyc(MEM2MBR, 16'h0001);
    cyc(MBR2BR, 16'h0);
    cyc(MEM2MBR, 16'h7FFF);
    cyc(MBR2ACC, 16'h0);
    check("ld_acc_flags", {24'h0, flags}, 32'h00);
    cyc(OP_ADD, 16'h0);
    check("add_flags", {24'h0, flags}, 32'h09);
    cyc(ACC2MBR, 16'h0);
    check("add_acc", {16'h0, mem_wdata}, 32'h8000);
    cyc(MEM2MBR, 16'h8000);
    cyc(MBR2BR, 16'h0);
    cyc(OP_SUB, 16'h0);
    check("sub_flags", {24'h0, flags}, 32'h06);
    cyc(ACC2MBR, 16'h0);
    check("sub_acc", {16'h0, mem_wdata}, 32'h0000);

    // Ignored bits must leave all state alone
    cyc(MEM2MBR, 16'hA5A5);
    cyc(ACC2ALU | BR2ALU | CAR_BITS | 32'h0000_0200, 16'h0);
    check("ignored_wdata", {16'h0, mem_wdata}, 32'hA5A5);
    check("ignored_flags", {24'h0, flags},     32'h06);

    // Store with PC wrap
    cyc(MEM2MBR, 16'h00FF);
    cyc(MBR2PC, 16'h0);
    cyc(MEM2MBR, 16'h0020);
    cyc(MBR2MAR | PC_PLUS1, 16'h0);
    check("store_addr", {24'h0, mem_addr}, 32'h20);
    cyc(MEM2MBR, 16'h1234);
    cyc(MBR2ACC, 16'h0);
    cyc(MEM2MBR, 16'h0);
    cyc(ACC2MBR, 16'h0);
    control_signal = MAR2MEM | MBR2MEM;
    #1;
    check("store_we",    {31'h0, mem_we},    32'h1);
    check("store_wdata", {16'h0, mem_wdata}, 32'h1234);
    check("store_addr2", {24'h0, mem_addr},  32'h20);
    @(posedge clk);
    #1;
    control_signal = 32'h0;
    #1;
    check("store_we_off", {31'h0, mem_we}, 32'h0);
    cyc(PC2MBR, 16'h0);
    check("pc_wrap", {16'h0, mem_wdata}, 32'h0000);

    // Multiply -2 * 3
    cyc(MEM2MBR, 16'h0003);
    cyc(MBR2BR, 16'h0);
    cyc(MEM2MBR, 16'hFFFE);
    cyc(MBR2ACC, 16'h0);
    cyc(OP_MPY, 16'h0);
    check("mpy_flags", {24'h0, flags}, 32'h01);
    cyc(ACC2MBR, 16'h0);
`ifdef DATAPATH_MPY_EN
    check("mpy_acc", {16'h0, mem_wdata}, 32'hFFFA);
    cyc(MR2MBR, 16'h0);
    check("mpy_mr", {16'h0, mem_wdata}, 32'hFFFF);
`else
    check("mpy_acc", {16'h0, mem_wdata}, 32'hFFFE);
    cyc(MR2MBR, 16'h0);
    check("mpy_mr", {16'h0, mem_wdata}, 32'h0000);
`endif

    // Priorities
    cyc(MEM2MBR, 16'h5555);
    cyc(OP_ADD | ACC_CLR | MBR2ACC, 16'h0);
    check("clr_flags", {24'h0, flags}, 32'h02);
    cyc(ACC2MBR, 16'h0);
    check("clr_acc", {16'h0, mem_wdata}, 32'h0000);
    cyc(MEM2MBR | ACC2MBR, 16'hBEEF);
    check("mbr_prio", {16'h0, mem_wdata}, 32'hBEEF);
    cyc(MEM2MBR, 16'h8001);
    cyc(MBR2ACC, 16'h0);
    cyc(OP_ASR, 16'h0);
    check("asr_flags", {24'h0, flags}, 32'h05);
    cyc(ACC2MBR, 16'h0);
    check("asr_acc", {16'h0, mem_wdata}, 32'hC000);

    // Asynchronous reset mid-instruction, then normal first edge
    @(negedge clk);
    control_signal = MAR2MEM | MBR2MEM;
    #1;
    rst = 1'b1;
    #1;
    check("arst_we",    {31'h0, mem_we},    32'h0);
    check("arst_wdata", {16'h0, mem_wdata}, 32'h0);
    check("arst_flags", {24'h0, flags},     32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(MEM2MBR, 16'h5A5A);
    check("post_rst", {16'h0, mem_wdata}, 32'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
